wb_pipe_reg: RTL

- Parametrised MEM→WB pipeline register for single- or multi-issue cores.
- Captures LANES independent register-write slots from the MEM stage and presents them to the register file.
- Uses the standard stall-vector semantics (hold vs. bubble), plus:
  - synchronous flush,
  - x0-write suppression,
  - intra-bundle write-after-write resolution,
  - a retired-write counter for performance monitoring.

---
 rtl/wb_pipe_reg.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/wb_pipe_reg.sv
// -----------------------------------------------------------------------------
// wb_pipe_reg
//   MEM->WB pipeline register for a core that issues one or more instructions
//   per cycle. It captures LANES independent register-write slots and presents
//   them to the register file one cycle later.
//
//   Write slots are cleaned up before capture:
//     - writes to x0 are dropped,
//     - when two or more lanes write the same register, only the highest lane
//       is kept, because it is the youngest in program order,
//     - a lane that is not writing shows all-zero address and data.
//   A counter tracks how many lane-writes have reached WB.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   stall       in   pipeline stall vector; only bits STAGE and STAGE+1 are used
//   flush       in   synchronous kill of the incoming bundle
//   mem_wd      in   per-lane destination address, lane i at [i*ADDR_W +: ADDR_W]
//   mem_wreg    in   per-lane write enable
//   mem_wdata   in   per-lane write data, lane i at [i*DATA_W +: DATA_W]
//   wb_wd       out  registered destination addresses
//   wb_wreg     out  registered write enables
//   wb_wdata    out  registered write data
//   wb_bubble   out  1 when the WB contents are an inserted bubble
//   retire_cnt  out  lane-writes committed to WB, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module wb_pipe_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned LANES   = 1,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned STAGE   = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic [LANES*ADDR_W-1:0]   mem_wd,
  input  logic [LANES-1:0]          mem_wreg,
  input  logic [LANES*DATA_W-1:0]   mem_wdata,
  output logic [LANES*ADDR_W-1:0]   wb_wd,
  output logic [LANES-1:0]          wb_wreg,
  output logic [LANES*DATA_W-1:0]   wb_wdata,
  output logic                      wb_bubble,
  output logic [CNT_W-1:0]          retire_cnt
);

  localparam int unsigned WD_W   = LANES * ADDR_W;
  localparam int unsigned DATA_V = LANES * DATA_W;
  localparam int unsigned POP_W  = $clog2(LANES + 1);

  // Reject configurations whose stall bits do not exist or lane counts
  // outside the supported range.
  if ((LANES < 1) || (LANES > 4) || ((STAGE + 1) >= STALL_W)) begin : g_bad_params
    $error("wb_pipe_reg: unsupported LANES/STAGE/STALL_W combination");
  end

  // What this edge does to the register.
  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2
  } action_e;

  action_e act_c;

  // Registered state and next-state.
  logic [WD_W-1:0]   wd_q,     wd_d;
  logic [LANES-1:0]  wreg_q,   wreg_d;
  logic [DATA_V-1:0] wdata_q,  wdata_d;
  logic              bubble_q, bubble_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  // Sanitised bundle.
  logic [LANES-1:0]  eff_wreg_c;
  logic [WD_W-1:0]   san_wd_c;
  logic [DATA_V-1:0] san_wdata_c;
  logic [POP_W-1:0]  pop_c;

  // Edge action: flush beats everything, then bubble, then hold.
  always_comb begin
    act_c = ACT_CAPTURE;
    if (flush) begin
      act_c = ACT_BUBBLE;
    end else if (stall[STAGE]) begin
      if (stall[STAGE+1]) begin
        act_c = ACT_HOLD;
      end else begin
        act_c = ACT_BUBBLE;
      end
    end
  end

  // Drop x0 writes and older lanes shadowed by a younger lane to the same
  // register. Comparing against the raw enable of the younger lane is enough:
  // an equal address is non-zero whenever the older lane is still enabled.
  always_comb begin
    eff_wreg_c  = '0;
    san_wd_c    = '0;
    san_wdata_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      eff_wreg_c[i] = mem_wreg[i] && (mem_wd[i*ADDR_W +: ADDR_W] != '0);
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (mem_wreg[j] &&
            (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W])) begin
          eff_wreg_c[i] = 1'b0;
        end
      end
      if (eff_wreg_c[i]) begin
        san_wd_c[i*ADDR_W +: ADDR_W]    = mem_wd[i*ADDR_W +: ADDR_W];
        san_wdata_c[i*DATA_W +: DATA_W] = mem_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Number of surviving writes in the bundle.
  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pop_c = pop_c + POP_W'(eff_wreg_c[i]);
    end
  end

  // Next-state selection; hold is the default.
  always_comb begin
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    bubble_d = bubble_q;
    cnt_d    = cnt_q;
    unique case (act_c)
      ACT_CAPTURE: begin
        wd_d     = san_wd_c;
        wreg_d   = eff_wreg_c;
        wdata_d  = san_wdata_c;
        bubble_d = 1'b0;
        cnt_d    = cnt_q + CNT_W'(pop_c);
      end
      ACT_BUBBLE: begin
        wd_d     = '0;
        wreg_d   = '0;
        wdata_d  = '0;
        bubble_d = 1'b1;
      end
      ACT_HOLD: begin
        wd_d     = wd_q;
      end
      default: begin
        wd_d     = wd_q;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q     <= '0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      bubble_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      bubble_q <= bubble_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wb_wd      = wd_q;
  assign wb_wreg    = wreg_q;
  assign wb_wdata   = wdata_q;
  assign wb_bubble  = bubble_q;
  assign retire_cnt = cnt_q;

endmodule
